// File: rtl/uart_rx_if.sv
// Receive-side handshake between uart_rx and the peripheral register block.
`timescale 1ns/1ps
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       framing_err;
    logic       overrun;
    logic       err_clear;

    modport master (
        output rx_data, rx_valid, framing_err, overrun,
        input  rx_ack, err_clear
    );

    modport slave (
        input  rx_data, rx_valid, framing_err, overrun,
        output rx_ack, err_clear
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, 16x oversampled with 3-sample majority vote at mid-bit.
// Define UART_RX_FIFO_EN for a 2^FIFO_DEPTH_LOG2-byte FIFO; otherwise a single holding register.
`timescale 1ns/1ps
module uart_rx
`ifdef UART_RX_FIFO_EN
#(
    parameter int FIFO_DEPTH_LOG2 = 3
)
`endif
(
    input  logic        clk,
    input  logic        reset,
    input  logic        rxd,
    input  logic [15:0] divisor,
    uart_rx_if.master   bus
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_rxd_s1, r_rxd_s2, r_rxd_prev;
    logic [15:0] r_tick_cnt;
    logic [3:0]  r_phase;
    logic        r_smp7, r_smp8;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        r_ferr, r_ovr;
    logic        w_tick, w_fall, w_decide, w_maj;
    logic        w_restart, w_shift, w_push, w_ferr_set, w_pop, w_ovr_set;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rxd_s1   <= 1'b1;
            r_rxd_s2   <= 1'b1;
            r_rxd_prev <= 1'b1;
        end else begin
            r_rxd_s1   <= rxd;
            r_rxd_s2   <= r_rxd_s1;
            r_rxd_prev <= r_rxd_s2;
        end
    end

    assign w_fall   = r_rxd_prev & ~r_rxd_s2;
    assign w_tick   = (r_tick_cnt == 16'd0);
    assign w_decide = w_tick && (r_phase == 4'd9);
    assign w_maj    = majority3(r_smp7, r_smp8, r_rxd_s2);

    // A start edge realigns both counters so phase 0 coincides with the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick_cnt <= 16'd0;
            r_phase    <= 4'd0;
            r_bit_cnt  <= 3'd0;
        end else begin
            if (w_restart) begin
                r_tick_cnt <= divisor;
                r_phase    <= 4'd0;
            end else if (w_tick) begin
                r_tick_cnt <= divisor;
                r_phase    <= r_phase + 4'd1;
            end else begin
                r_tick_cnt <= r_tick_cnt - 16'd1;
            end
            if (w_restart)
                r_bit_cnt <= 3'd0;
            else if (w_shift)
                r_bit_cnt <= r_bit_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_tick && r_phase == 4'd7) r_smp7 <= r_rxd_s2;
        if (w_tick && r_phase == 4'd8) r_smp8 <= r_rxd_s2;
        if (w_shift) r_shift <= {w_maj, r_shift[7:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_restart   = 1'b0;
        w_shift     = 1'b0;
        w_push      = 1'b0;
        w_ferr_set  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_restart   = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_decide) w_state_nxt = w_maj ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (w_decide) begin
                    w_shift = 1'b1;
                    if (r_bit_cnt == 3'd7) w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_decide) begin
                    if (w_maj) begin
                        w_push      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_ferr_set  = 1'b1;
                        w_state_nxt = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (r_rxd_s2) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef UART_RX_FIFO_EN
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

    logic [7:0]               r_mem [DEPTH];
    logic [FIFO_DEPTH_LOG2:0] r_wptr, r_rptr;
    logic                     w_empty, w_full, w_wr;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[FIFO_DEPTH_LOG2] != r_rptr[FIFO_DEPTH_LOG2]) &&
                       (r_wptr[FIFO_DEPTH_LOG2-1:0] == r_rptr[FIFO_DEPTH_LOG2-1:0]);
    assign w_pop     = bus.rx_ack && !w_empty;
    assign w_wr      = w_push && (!w_full || w_pop);
    assign w_ovr_set = w_push && w_full && !w_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr)  r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr[FIFO_DEPTH_LOG2-1:0]] <= r_shift;
    end

    assign bus.rx_valid = !w_empty;
    assign bus.rx_data  = w_empty ? 8'h00 : r_mem[r_rptr[FIFO_DEPTH_LOG2-1:0]];
`else
    logic [7:0] r_hold;
    logic       r_valid;

    assign w_pop     = bus.rx_ack && r_valid;
    assign w_ovr_set = w_push && r_valid && !w_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold  <= 8'h00;
            r_valid <= 1'b0;
        end else if (w_push && (!r_valid || w_pop)) begin
            r_hold  <= r_shift;
            r_valid <= 1'b1;
        end else if (w_pop) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.rx_valid = r_valid;
    assign bus.rx_data  = r_hold;
`endif

    // A new overrun wins over a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ferr <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            r_ferr <= w_ferr_set;
            if (w_ovr_set)          r_ovr <= 1'b1;
            else if (bus.err_clear) r_ovr <= 1'b0;
        end
    end

    assign bus.framing_err = r_ferr;
    assign bus.overrun     = r_ovr;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame table plus hand-written corner sequences, scoreboard of expected bytes.
`timescale 1ns/1ps
module tb_uart_rx;
`ifdef UART_RX_FIFO_EN
    localparam int DEPTH = 8;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        rxd;
    logic [15:0] divisor;

    uart_rx_if u_if ();

    uart_rx dut (
        .clk     (clk),
        .reset   (reset),
        .rxd     (rxd),
        .divisor (divisor),
        .bus     (u_if.master)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_push;
        logic       exp_ferr;
    } vec_t;

    vec_t       vecs [6];
    logic [7:0] exp_q [$];
    int         checks   = 0;
    int         failures = 0;
    int         ferr_cnt = 0;
    int         bitc     = 16;

    always @(negedge clk) if (u_if.framing_err === 1'b1) ferr_cnt <= ferr_cnt + 1;

    initial begin
        #(90000 * 20);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic set_div(input int d);
        divisor = d[15:0];
        bitc    = 16 * (d + 1);
    endtask

    task automatic idle(input int nbits);
        rxd = 1'b1;
        repeat (nbits * bitc) @(negedge clk);
    endtask

    // Called on a negedge; each bit is held for exactly bitc cycles.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        rxd = 1'b0;
        repeat (bitc) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (bitc) @(negedge clk);
        end
        rxd = stop;
        repeat (bitc) @(negedge clk);
        rxd = 1'b1;
    endtask

    // rx_ack is held across the clock edge that closes the stop-bit decision cycle.
    task automatic timed_frame(input logic [7:0] d);
        fork
            send_frame(d, 1'b1);
            begin
                repeat (2 + 154 * (bitc / 16)) @(negedge clk);
                u_if.rx_ack = 1'b1;
                @(negedge clk);
                u_if.rx_ack = 1'b0;
            end
        join
    endtask

    task automatic drain();
        logic [7:0] e;
        int w;
        while (exp_q.size() > 0) begin
            w = 0;
            while (!u_if.rx_valid && w < 2000) begin
                @(negedge clk);
                w++;
            end
            if (!u_if.rx_valid) begin
                chk("drain_wait_valid", u_if.rx_valid, 1);
                exp_q.delete();
            end else begin
                e = exp_q.pop_front();
                chk("rx_data", u_if.rx_data, e);
                u_if.rx_ack = 1'b1;
                @(negedge clk);
                u_if.rx_ack = 1'b0;
            end
        end
        chk("rx_valid_after_drain", u_if.rx_valid, 0);
    endtask

    initial begin
        int lat;
        int f0;
        logic [7:0] b;

        vecs[0] = '{8'h5A, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'h3C, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'h11, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'h96, 1'b1, 1'b1, 1'b0};

        reset          = 1'b1;
        rxd            = 1'b1;
        u_if.rx_ack    = 1'b0;
        u_if.err_clear = 1'b0;
        set_div(26);
        repeat (3) @(negedge clk);
        chk("reset_rx_data", u_if.rx_data, 0);
        chk("reset_rx_valid", u_if.rx_valid, 0);
        chk("reset_framing_err", u_if.framing_err, 0);
        chk("reset_overrun", u_if.overrun, 0);
        reset = 1'b0;
        idle(1);

        // Single byte at ~115200 baud, with start-edge to rx_valid latency.
        exp_q.push_back(8'hA5);
        lat = 0;
        fork
            send_frame(8'hA5, 1'b1);
            while (!u_if.rx_valid && lat < 6000) begin
                @(negedge clk);
                lat++;
            end
        join
        checks++;
        if (lat < 4159 || lat > 4163) begin
            failures++;
            $display("FAIL latency actual=%0d required=4161+-2", lat);
        end
        drain();

        set_div(3);
        idle(2);

        // Short low pulse (4 ticks) must be rejected silently.
        f0 = ferr_cnt;
        rxd = 1'b0;
        repeat (4 * (bitc / 16)) @(negedge clk);
        idle(2);
        chk("glitch_rx_valid", u_if.rx_valid, 0);
        chk("glitch_framing_err", ferr_cnt - f0, 0);

        for (int i = 0; i < 6; i++) begin
            f0 = ferr_cnt;
            if (vecs[i].exp_push) exp_q.push_back(vecs[i].data);
            send_frame(vecs[i].data, vecs[i].stop);
            if (!vecs[i].stop) begin
                rxd = 1'b0;
                repeat (20 * bitc) @(negedge clk);
            end
            idle(2);
            chk($sformatf("vec%0d_ferr_pulses", i), ferr_cnt - f0, int'(vecs[i].exp_ferr));
            chk($sformatf("vec%0d_rx_valid", i), u_if.rx_valid, int'(vecs[i].exp_push));
            drain();
        end

        // Overrun: DEPTH+1 bytes without ack; the last one is dropped.
        for (int i = 0; i <= DEPTH; i++) begin
            if (DEPTH == 1) b = (i == 0) ? 8'h55 : 8'h66;
            else            b = 8'(i);
            if (i < DEPTH) exp_q.push_back(b);
            send_frame(b, 1'b1);
            idle(1);
        end
        idle(1);
        chk("overrun_set", u_if.overrun, 1);
        chk("overrun_head", u_if.rx_data, int'(exp_q[0]));
        u_if.err_clear = 1'b1;
        @(negedge clk);
        u_if.err_clear = 1'b0;
        chk("overrun_cleared", u_if.overrun, 0);
        drain();

        // Reset in the middle of the 4th data bit with a byte buffered and overrun set.
        for (int i = 0; i <= DEPTH; i++) begin
            send_frame(8'h70 + 8'(i), 1'b1);
            idle(1);
        end
        chk("pre_reset_overrun", u_if.overrun, 1);
        b = 8'hE7;
        rxd = 1'b0;
        repeat (bitc) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rxd = b[i];
            repeat (bitc) @(negedge clk);
        end
        rxd = b[3];
        repeat (bitc / 2) @(negedge clk);
        reset = 1'b1;
        rxd   = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("midreset_rx_valid", u_if.rx_valid, 0);
        chk("midreset_rx_data", u_if.rx_data, 0);
        chk("midreset_overrun", u_if.overrun, 0);
        chk("midreset_framing_err", u_if.framing_err, 0);
        idle(2);
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1);
        idle(2);
        drain();

        // Push and pop in the same cycle while empty: byte is kept.
        exp_q.push_back(8'h99);
        timed_frame(8'h99);
        idle(1);
        chk("emptypp_rx_valid", u_if.rx_valid, 1);
        drain();

        // Push and pop in the same cycle while full: no overrun, count unchanged.
        for (int i = 0; i < DEPTH; i++) begin
            send_frame(8'h80 + 8'(i), 1'b1);
            idle(1);
            exp_q.push_back(8'h81 + 8'(i));
        end
        timed_frame(8'h80 + 8'(DEPTH));
        idle(1);
        chk("fullpp_overrun", u_if.overrun, 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
